// File: rtl/multicycle_control.sv
// multicycle_control
// Multi-cycle control FSM for the RV32I core. It sequences FETCH, DECODE,
// EXEC, MEM and WB over one shared instruction/data memory with a valid/ready
// handshake, and drives the IR, PC, register-file and memory enables and the
// operand / write-back mux selects. Only the state and the sticky illegal
// flag are registered. Every other output is decoded from the current state
// and the live inputs, so a memory access finishes in its mem_ready cycle.
// Build option: define PERF_CNT_EN to add the cycle_cnt and instret_cnt
// performance counters. They are CNT_W bits wide and wrap around.
module multicycle_control #(
  parameter int CNT_W           = 32,
  parameter bit HALT_ON_ILLEGAL = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       opcode,
  input  logic [2:0]       funct3,
  input  logic             brEq,
  input  logic             brLt,
  input  logic             mem_ready,
  output logic             mem_valid,
  output logic             memRead,
  output logic             memWrite,
  output logic             mem_inst,
  output logic             IRWrite,
  output logic             PCWrite,
  output logic             PCSel,
  output logic             ALUSrc1,
  output logic             ALUSrc2,
  output logic [2:0]       ALUOp,
  output logic             regWrite,
  output logic [1:0]       memtoReg,
  output logic [2:0]       state,
  output logic             illegal,
`ifdef PERF_CNT_EN
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt,
`endif
  output logic             halted
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    HALT   = 3'd5
  } stateT;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  stateT curState;
  stateT nextState;

  logic isR, isI, isLoad, isStore, isBranch, isJal, isJalr, isLui, isAuipc;
  logic isLegal;
  logic isLink;
  logic taken;

  // Reject a zero counter width at elaboration, whether or not the counters are built
  if (CNT_W < 1) begin : gCntWidthCheck
    $error("multicycle_control: CNT_W must be at least 1");
  end

  // Classify the opcode held in IR and evaluate the signed branch condition
  always_comb begin
    isR      = (opcode == OP_R);
    isI      = (opcode == OP_I);
    isLoad   = (opcode == OP_LOAD);
    isStore  = (opcode == OP_STORE);
    isBranch = (opcode == OP_BRANCH);
    isJal    = (opcode == OP_JAL);
    isJalr   = (opcode == OP_JALR);
    isLui    = (opcode == OP_LUI);
    isAuipc  = (opcode == OP_AUIPC);
    isLink   = isJal | isJalr;
    isLegal  = isR | isI | isLoad | isStore | isBranch | isJal | isJalr | isLui | isAuipc;
    taken    = 1'b0;
    case (funct3)
      3'b000:  taken = brEq;
      3'b001:  taken = ~brEq;
      3'b100:  taken = brLt;
      3'b101:  taken = ~brLt;
      default: taken = 1'b0;
    endcase
  end

  // Next-state logic. Memory states wait for mem_ready and HALT only leaves through reset.
  always_comb begin
    nextState = curState;
    case (curState)
      FETCH:  if (mem_ready) nextState = DECODE;
      DECODE: begin
        if (isLegal)              nextState = EXEC;
        else if (HALT_ON_ILLEGAL) nextState = HALT;
        else                      nextState = FETCH;
      end
      EXEC: begin
        if (isLoad | isStore)                         nextState = MEM;
        else if (isR | isI | isLui | isAuipc | isLink) nextState = WB;
        else                                          nextState = FETCH;
      end
      MEM:    if (mem_ready) nextState = isLoad ? WB : FETCH;
      WB:     nextState = FETCH;
      HALT:   nextState = HALT;
      default: nextState = FETCH;
    endcase
  end

  // State register and sticky illegal-opcode flag, both cleared by synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      curState <= FETCH;
      illegal  <= 1'b0;
    end else begin
      curState <= nextState;
      if (curState == DECODE && !isLegal) illegal <= 1'b1;
    end
  end

  assign state  = curState;
  assign halted = (curState == HALT);

  // Datapath enables and selects. Reset forces all of them to zero, which abandons any access in flight.
  always_comb begin
    mem_valid = 1'b0;
    memRead   = 1'b0;
    memWrite  = 1'b0;
    mem_inst  = 1'b0;
    IRWrite   = 1'b0;
    PCWrite   = 1'b0;
    PCSel     = 1'b0;
    ALUSrc1   = 1'b0;
    ALUSrc2   = 1'b0;
    ALUOp     = 3'b000;
    regWrite  = 1'b0;
    memtoReg  = 2'd0;
    if (!rst) begin
      case (curState)
        FETCH: begin
          mem_valid = 1'b1;
          memRead   = 1'b1;
          mem_inst  = 1'b1;
          if (mem_ready) begin
            IRWrite = 1'b1;
            PCWrite = 1'b1;
          end
        end
        EXEC: begin
          if (isR) begin
            ALUOp = 3'b010;
          end else if (isI) begin
            ALUOp   = 3'b011;
            ALUSrc2 = 1'b1;
          end else if (isLui) begin
            ALUOp   = 3'b100;
            ALUSrc2 = 1'b1;
          end else if (isLoad | isStore | isJalr) begin
            ALUSrc2 = 1'b1;
          end else if (isAuipc | isJal) begin
            ALUSrc1 = 1'b1;
            ALUSrc2 = 1'b1;
          end else if (isBranch) begin
            ALUSrc1 = 1'b1;
            ALUSrc2 = 1'b1;
            PCWrite = taken;
            PCSel   = 1'b1;
          end
        end
        MEM: begin
          mem_valid = 1'b1;
          memRead   = isLoad;
          memWrite  = isStore;
        end
        WB: begin
          regWrite = 1'b1;
          if (isLoad)      memtoReg = 2'd1;
          else if (isLink) memtoReg = 2'd2;
          PCWrite = isLink;
          PCSel   = isLink;
        end
        default: ;
      endcase
    end
  end

`ifdef PERF_CNT_EN
  logic retire;

  assign retire = (nextState == FETCH) &&
                  (curState == EXEC || curState == MEM || curState == WB);

  // Count every active non-halted cycle and every instruction that returns to FETCH
  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_cnt   <= '0;
      instret_cnt <= '0;
    end else begin
      if (curState != HALT) cycle_cnt   <= cycle_cnt + CNT_W'(1);
      if (retire)           instret_cnt <= instret_cnt + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control
// Randomized bench for multicycle_control. Each instruction is expanded into
// the list of cycles it should take, given its class and the memory wait
// counts. Each cycle in that list carries the expected state and control
// word. The bench replays the list against the DUT one clock at a time.
// With PERF_CNT_EN defined, the performance counters are checked too.
module tb_multicycle_control;

  localparam int CNT_W = 32;

  localparam int K_R     = 0;
  localparam int K_I     = 1;
  localparam int K_LD    = 2;
  localparam int K_ST    = 3;
  localparam int K_BR    = 4;
  localparam int K_JAL   = 5;
  localparam int K_JALR  = 6;
  localparam int K_LUI   = 7;
  localparam int K_AUIPC = 8;
  localparam int K_ILL   = 9;

  localparam logic [31:0] B_MV  = 32'h1 << 16;
  localparam logic [31:0] B_MR  = 32'h1 << 15;
  localparam logic [31:0] B_MW  = 32'h1 << 14;
  localparam logic [31:0] B_MI  = 32'h1 << 13;
  localparam logic [31:0] B_IRW = 32'h1 << 12;
  localparam logic [31:0] B_PCW = 32'h1 << 11;
  localparam logic [31:0] B_PCS = 32'h1 << 10;
  localparam logic [31:0] B_S1  = 32'h1 << 9;
  localparam logic [31:0] B_S2  = 32'h1 << 8;
  localparam logic [31:0] B_RW  = 32'h1 << 4;
  localparam logic [31:0] B_IL  = 32'h1 << 1;
  localparam logic [31:0] B_HA  = 32'h1;

  typedef struct {
    logic        ready;
    logic        fetchPhase;
    logic [2:0]  st;
    logic [31:0] ctrl;
  } cycleT;

  logic clk = 1'b0;
  logic rst;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic brEq, brLt, mem_ready;
  logic mem_valid, memRead, memWrite, mem_inst, IRWrite, PCWrite, PCSel;
  logic ALUSrc1, ALUSrc2, regWrite, illegal, halted;
  logic [2:0] ALUOp;
  logic [1:0] memtoReg;
  logic [2:0] state;
`ifdef PERF_CNT_EN
  logic [CNT_W-1:0] cycle_cnt, instret_cnt;
  logic [CNT_W-1:0] expCycles, expInstret;
`endif

  int checks = 0;
  int errors = 0;
  logic expIllegal;

  // Free-running 10-time-unit clock
  always #5 clk = ~clk;

  multicycle_control #(.CNT_W(CNT_W), .HALT_ON_ILLEGAL(1'b1)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3),
    .brEq(brEq), .brLt(brLt), .mem_ready(mem_ready),
    .mem_valid(mem_valid), .memRead(memRead), .memWrite(memWrite),
    .mem_inst(mem_inst), .IRWrite(IRWrite), .PCWrite(PCWrite), .PCSel(PCSel),
    .ALUSrc1(ALUSrc1), .ALUSrc2(ALUSrc2), .ALUOp(ALUOp),
    .regWrite(regWrite), .memtoReg(memtoReg), .state(state),
    .illegal(illegal),
`ifdef PERF_CNT_EN
    .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt),
`endif
    .halted(halted)
  );

  function automatic logic [6:0] opcodeOf(input int cls);
    case (cls)
      K_R:     return 7'b0110011;
      K_I:     return 7'b0010011;
      K_LD:    return 7'b0000011;
      K_ST:    return 7'b0100011;
      K_BR:    return 7'b1100011;
      K_JAL:   return 7'b1101111;
      K_JALR:  return 7'b1100111;
      K_LUI:   return 7'b0110111;
      K_AUIPC: return 7'b0010111;
      default: return 7'b0000000;
    endcase
  endfunction

  function automatic string nameOf(input int cls);
    case (cls)
      K_R:     return "add";
      K_I:     return "addi";
      K_LD:    return "lw";
      K_ST:    return "sw";
      K_BR:    return "branch";
      K_JAL:   return "jal";
      K_JALR:  return "jalr";
      K_LUI:   return "lui";
      K_AUIPC: return "auipc";
      default: return "illegal";
    endcase
  endfunction

  function automatic logic [31:0] aluOpBits(input logic [2:0] op);
    return {29'b0, op} << 5;
  endfunction

  function automatic logic [31:0] mtrBits(input logic [1:0] sel);
    return {30'b0, sel} << 2;
  endfunction

  function automatic cycleT mkCycle(input logic ready, input logic fetchPhase,
                                    input logic [2:0] st, input logic [31:0] ctrl);
    cycleT c;
    c.ready      = ready;
    c.fetchPhase = fetchPhase;
    c.st         = st;
    c.ctrl       = ctrl;
    return c;
  endfunction

  // Branch outcome from the table of supported conditions: beq, bne, blt, bge
  function automatic logic branchTaken(input logic [2:0] f3, input logic eq, input logic lt);
    logic t;
    t = 1'b0;
    if (f3 == 3'b000) t = eq;
    if (f3 == 3'b001) t = !eq;
    if (f3 == 3'b100) t = lt;
    if (f3 == 3'b101) t = !lt;
    return t;
  endfunction

  // EXEC control word for each instruction class
  function automatic logic [31:0] execCtrl(input int cls, input logic [2:0] f3,
                                           input logic eq, input logic lt);
    case (cls)
      K_R:     return aluOpBits(3'b010);
      K_I:     return aluOpBits(3'b011) | B_S2;
      K_LD:    return B_S2;
      K_ST:    return B_S2;
      K_LUI:   return aluOpBits(3'b100) | B_S2;
      K_AUIPC: return B_S1 | B_S2;
      K_JAL:   return B_S1 | B_S2;
      K_JALR:  return B_S2;
      K_BR:    return B_S1 | B_S2 | B_PCS | (branchTaken(f3, eq, lt) ? B_PCW : 32'h0);
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] packCtrl();
    return {15'b0, mem_valid, memRead, memWrite, mem_inst, IRWrite, PCWrite, PCSel,
            ALUSrc1, ALUSrc2, ALUOp, regWrite, memtoReg, illegal, halted};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Hold rst for n cycles with mem_ready high; clears the model's sticky state
  task automatic doReset(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rst       = 1'b1;
      mem_ready = 1'b1;
      opcode    = 7'($urandom);
      #1;
      checkOutput($sformatf("reset c%0d enables", i), packCtrl() & ~32'h3, 32'h0);
      if (i > 0) begin
        checkOutput($sformatf("reset c%0d state", i), {29'b0, state}, 32'h0);
        checkOutput($sformatf("reset c%0d flags", i), packCtrl(), 32'h0);
`ifdef PERF_CNT_EN
        checkOutput("reset cycle_cnt", cycle_cnt, 32'h0);
        checkOutput("reset instret_cnt", instret_cnt, 32'h0);
`endif
      end
    end
    expIllegal = 1'b0;
`ifdef PERF_CNT_EN
    expCycles  = '0;
    expInstret = '0;
`endif
  endtask

  // Expand one instruction into its expected cycles and replay them.
  // abortAfter >= 0 stops after that many cycles so that a reset can hit mid-access.
  task automatic applyStimulus(input int cls, input logic [2:0] f3, input logic eq,
                               input logic lt, input int fw, input int mw,
                               input int abortAfter);
    cycleT q[$];
    logic [6:0] op;
    logic [31:0] wbCtrl;
    bit aborted;
    op = opcodeOf(cls);
    aborted = 0;
    for (int i = 0; i <= fw; i++)
      q.push_back(mkCycle(i == fw, 1'b1, 3'd0,
                          B_MV | B_MR | B_MI | ((i == fw) ? (B_IRW | B_PCW) : 32'h0)));
    q.push_back(mkCycle(1'($urandom_range(0, 1)), 1'b0, 3'd1, 32'h0));
    if (cls == K_ILL) begin
      for (int i = 0; i < 20; i++)
        q.push_back(mkCycle(1'($urandom_range(0, 1)), 1'b0, 3'd5, B_IL | B_HA));
    end else begin
      q.push_back(mkCycle(1'($urandom_range(0, 1)), 1'b0, 3'd2, execCtrl(cls, f3, eq, lt)));
      if (cls == K_LD || cls == K_ST) begin
        for (int i = 0; i <= mw; i++)
          q.push_back(mkCycle(i == mw, 1'b0, 3'd3,
                              B_MV | ((cls == K_LD) ? B_MR : 32'h0) | ((cls == K_ST) ? B_MW : 32'h0)));
      end
      if (cls != K_BR && cls != K_ST) begin
        wbCtrl = B_RW;
        if (cls == K_LD) wbCtrl |= mtrBits(2'd1);
        if (cls == K_JAL || cls == K_JALR) wbCtrl |= mtrBits(2'd2) | B_PCW | B_PCS;
        q.push_back(mkCycle(1'($urandom_range(0, 1)), 1'b0, 3'd4, wbCtrl));
      end
    end
    for (int k = 0; k < q.size(); k++) begin
      if (abortAfter >= 0 && k >= abortAfter) begin
        aborted = 1;
        break;
      end
      @(negedge clk);
      rst       = 1'b0;
      mem_ready = q[k].ready;
      opcode    = q[k].fetchPhase ? 7'($urandom) : op;
      funct3    = f3;
      brEq      = eq;
      brLt      = lt;
      #1;
      checkOutput($sformatf("%s c%0d state", nameOf(cls), k), {29'b0, state}, {29'b0, q[k].st});
      checkOutput($sformatf("%s c%0d ctrl", nameOf(cls), k), packCtrl(),
                  q[k].ctrl | (expIllegal ? B_IL : 32'h0));
`ifdef PERF_CNT_EN
      checkOutput($sformatf("%s c%0d cycle_cnt", nameOf(cls), k), cycle_cnt, expCycles);
      checkOutput($sformatf("%s c%0d instret_cnt", nameOf(cls), k), instret_cnt, expInstret);
      if (q[k].st != 3'd5) expCycles++;
`endif
    end
    if (cls == K_ILL) expIllegal = 1'b1;
`ifdef PERF_CNT_EN
    if (cls != K_ILL && !aborted) expInstret++;
`endif
  endtask

  // Directed cases from the block's checklist, then a randomized instruction stream
  initial begin
    int cls, fw, mw;
    rst        = 1'b1;
    mem_ready  = 1'b1;
    opcode     = 7'b0;
    funct3     = 3'b0;
    brEq       = 1'b0;
    brLt       = 1'b0;
    expIllegal = 1'b0;
`ifdef PERF_CNT_EN
    expCycles  = '0;
    expInstret = '0;
`endif
    doReset(2);

    applyStimulus(K_R,   3'b000, 1'b0, 1'b0, 0, 0, -1);
    applyStimulus(K_LD,  3'b010, 1'b0, 1'b0, 0, 3, -1);
    applyStimulus(K_BR,  3'b000, 1'b1, 1'b0, 0, 0, -1);
    applyStimulus(K_BR,  3'b000, 1'b0, 1'b0, 0, 0, -1);
    applyStimulus(K_JAL, 3'b000, 1'b0, 1'b0, 0, 0, -1);
    applyStimulus(K_ST,  3'b010, 1'b0, 1'b0, 2, 1, -1);

    for (int n = 0; n < 60; n++) begin
      cls = $urandom_range(K_R, K_AUIPC);
      fw  = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 4) : 0;
      mw  = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 4) : 0;
      applyStimulus(cls, 3'($urandom), 1'($urandom), 1'($urandom), fw, mw, -1);
    end

    applyStimulus(K_ST, 3'b010, 1'b0, 1'b0, 0, 3, 5);
    doReset(1);
    applyStimulus(K_I, 3'b000, 1'b0, 1'b0, 0, 0, -1);

    applyStimulus(K_ILL, 3'b000, 1'b0, 1'b0, 1, 0, -1);
    doReset(2);
    applyStimulus(K_R, 3'b000, 1'b0, 1'b0, 0, 0, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
